delay_param_sequencer: RTL and testbench
========================================

# delay_param_sequencer

- Sequences the delay effect's control parameters: `delay_samples`, `feedback_amount`, `effect_amount` and `mode`.
- Accepts a new parameter set through a valid/ready strobe. It glides `delay_samples`, feedback and wet mix toward the targets in sample-rate steps to avoid zipper noise and pitch jumps.
- On a mode change it mutes the wet path, switches mode, flushes the buffer, then fades back in.
- Sits between the control/UI register bank and the delay effect's control inputs, clocked on the audio clock and paced by the same `sample_valid`.

## Interface
- ADDR_WIDTH, 16, width of delay values in samples
- DELAY_STEP, 4, max change of `delay_samples` per sample tick during glide
- FADE_STEP, 2, max change of `feedback_amount` / `effect_amount` per sample tick
- RESET_DELAY, 4800, `delay_samples` value after reset

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle audio sample tick; the same strobe that feeds the delay effect
- cfg_valid  in  1  new target set present
- cfg_ready  out  1  high only in IDLE; a config is accepted on cfg_valid && cfg_ready
- target_delay  in  ADDR_WIDTH  requested delay in samples
- target_feedback  in  8  requested feedback amount, 0-255
- target_effect  in  8  requested wet mix, 0-255
- target_mode  in  1  requested mode: 0=feedforward, 1=feedback
- delay_samples  out  ADDR_WIDTH  registered, to the delay effect
- feedback_amount  out  8  registered, to the delay effect
- effect_amount  out  8  registered, to the delay effect
- mode  out  1  registered, to the delay effect
- busy  out  1  high whenever state != IDLE

## Operation
- Targets are latched into internal registers on acceptance. cfg_valid while cfg_ready=0 is ignored; the config is dropped, not queued.
- States: IDLE, FADE_OUT, SWITCH, FLUSH, GLIDE.
- IDLE, on accept:
  - target_mode != mode -> FADE_OUT
  - otherwise -> GLIDE
- FADE_OUT, on each sample_valid: `effect_amount` and `feedback_amount` each step toward 0.
  - When both are 0 -> SWITCH, evaluated on the registered values.
- SWITCH: exactly one clk, independent of sample_valid.
  - `mode <= target_mode`
  - `delay_samples <= target_delay` (jump allowed because the wet path is muted)
  - flush counter cleared
  - -> FLUSH
- FLUSH: counter increments on each sample_valid.
  - When counter == target_delay -> GLIDE. Counter is ADDR_WIDTH bits.
  - target_delay=0 exits on the first clk in FLUSH.
- GLIDE, on each sample_valid: `delay_samples` steps by up to DELAY_STEP, and `feedback_amount` / `effect_amount` by up to FADE_STEP, each toward its target.
  - When all three equal their targets -> IDLE. Checked every clk, not just on ticks.
- Step rule, unsigned, no overshoot: if |target - cur| <= STEP then cur <= target, else cur <= cur ± STEP. Differences are computed at width+1 bits so no wrap-around.
- `mode` changes only in SWITCH. `delay_samples` never changes in FADE_OUT or FLUSH.

## Timing
- Reset values:
  - delay_samples=RESET_DELAY, feedback_amount=0, effect_amount=0, mode=0
  - state IDLE, cfg_ready=1, busy=0
  - latched targets = reset output values
- Reset mid-sequence takes effect on the next edge and overrides everything; no fade is performed.
- Accept at edge N: at N+1 state has left IDLE, cfg_ready=0 and busy=1.
- Outputs change on the edge where sample_valid is sampled high, so a new value is visible 1 clk after the tick. The delay effect therefore uses it from the next sample on.
- A no-op config (targets equal to current values, same mode) goes IDLE -> GLIDE -> IDLE, with busy high for exactly 1 clk.
- Glide duration in sample ticks = max(ceil(|Δdelay|/DELAY_STEP), ceil(|Δfb|/FADE_STEP), ceil(|Δeff|/FADE_STEP)).
- Mode-change duration in ticks = fade-out ticks + target_delay + fade-in ticks, plus 1 clk for SWITCH.
- If sample_valid is high on the SWITCH cycle, that tick is not counted by FLUSH.

## Test plan
- **Reset and no-op:** after reset, apply cfg(4800, 0, 0, 0) -> outputs unchanged; busy high for 1 clk; cfg_ready low for 1 clk.
- **Delay glide up:** from reset, cfg delay=4810 (same mode, fb=0, eff=0), ticks every 8 clk -> delay_samples goes 4804, 4808, 4810, each 1 clk after a tick; returns to IDLE after 3 ticks.
- **Mix fade both directions:** from eff=0/fb=0, cfg eff=5, fb=4 -> eff 2, 4, 5 and fb 2, 4. A following cfg eff=0, fb=0 -> eff 3, 1, 0 and fb 2, 0 with no underflow.
- **Mode change with flush:**
  - Stimulus: state mode=0, eff=4, fb=2, delay=4800; cfg mode=1, delay=10, eff=4, fb=2.
  - FADE_OUT: 2 ticks to reach eff=0, fb=0.
  - SWITCH: mode=1, delay=10.
  - FLUSH: exactly 10 ticks with eff=0.
  - GLIDE: eff/fb reach 4/2 in 2 ticks.
- **Dropped config:** cfg_valid pulsed while busy with target_delay=100 -> ignored; final delay equals the first accepted target.
- **Reset mid-operation:** assert reset during FLUSH -> next clk all outputs are at reset values, state IDLE, cfg_ready=1. A new cfg is then accepted normally.

Source files
------------

// File: rtl/delay_param_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : delay_param_sequencer
// Description : Glides delay-effect control parameters toward accepted targets
//               one sample tick at a time; mode changes mute, switch, flush,
//               then fade back in.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_param_sequencer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DELAY_STEP  = 4,
    parameter int FADE_STEP   = 2,
    parameter int RESET_DELAY = 4800
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_WIDTH-1:0] target_delay,
    input  logic [7:0]            target_feedback,
    input  logic [7:0]            target_effect,
    input  logic                  target_mode,
    output logic [ADDR_WIDTH-1:0] delay_samples,
    output logic [7:0]            feedback_amount,
    output logic [7:0]            effect_amount,
    output logic                  mode,
    output logic                  busy
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_fade_out = 3'd1;
    localparam logic [2:0] c_st_switch   = 3'd2;
    localparam logic [2:0] c_st_flush    = 3'd3;
    localparam logic [2:0] c_st_glide    = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_reset_delay  = ADDR_WIDTH'(RESET_DELAY);
    localparam logic [ADDR_WIDTH-1:0] c_delay_step   = ADDR_WIDTH'(DELAY_STEP);
    localparam logic [ADDR_WIDTH:0]   c_delay_step_w = (ADDR_WIDTH+1)'(DELAY_STEP);
    localparam logic [ADDR_WIDTH-1:0] c_cnt_one      = ADDR_WIDTH'(1);
    localparam logic [7:0]            c_fade_step    = 8'(FADE_STEP);
    localparam logic [8:0]            c_fade_step_w  = 9'(FADE_STEP);

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_tgt_delay;
    logic [7:0]            r_tgt_fb;
    logic [7:0]            r_tgt_eff;
    logic                  r_tgt_mode;
    logic [ADDR_WIDTH-1:0] r_delay;
    logic [7:0]            r_fb;
    logic [7:0]            r_eff;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_flush_cnt;
    logic                  w_cfg_ready;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_at_target;

    // Differences are taken one bit wider than the operands so they never wrap.
    function automatic logic [ADDR_WIDTH-1:0] f_step_delay(
        input logic [ADDR_WIDTH-1:0] cur,
        input logic [ADDR_WIDTH-1:0] tgt
    );
        logic [ADDR_WIDTH:0] diff;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            f_step_delay = (diff <= c_delay_step_w) ? tgt : cur + c_delay_step;
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            f_step_delay = (diff <= c_delay_step_w) ? tgt : cur - c_delay_step;
        end
    endfunction

    function automatic logic [7:0] f_step_amount(
        input logic [7:0] cur,
        input logic [7:0] tgt
    );
        logic [8:0] diff;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            f_step_amount = (diff <= c_fade_step_w) ? tgt : cur + c_fade_step;
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            f_step_amount = (diff <= c_fade_step_w) ? tgt : cur - c_fade_step;
        end
    endfunction

    assign w_at_target = (r_delay == r_tgt_delay) && (r_fb == r_tgt_fb) &&
                         (r_eff == r_tgt_eff);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_next = (target_mode != r_mode) ? c_st_fade_out : c_st_glide;
                end
            end
            c_st_fade_out: begin
                if ((r_eff == 8'd0) && (r_fb == 8'd0)) begin
                    w_state_next = c_st_switch;
                end
            end
            c_st_switch: begin
                w_state_next = c_st_flush;
            end
            c_st_flush: begin
                if (r_flush_cnt == r_tgt_delay) begin
                    w_state_next = c_st_glide;
                end
            end
            c_st_glide: begin
                if (w_at_target) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_comb begin
        w_cfg_ready = (r_state == c_st_idle);
        w_busy      = (r_state != c_st_idle);
        w_accept    = cfg_valid && w_cfg_ready;
    end

    // Datapath: targets, parameter outputs and the flush counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tgt_delay <= c_reset_delay;
            r_tgt_fb    <= 8'd0;
            r_tgt_eff   <= 8'd0;
            r_tgt_mode  <= 1'b0;
            r_delay     <= c_reset_delay;
            r_fb        <= 8'd0;
            r_eff       <= 8'd0;
            r_mode      <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_tgt_delay <= target_delay;
                r_tgt_fb    <= target_feedback;
                r_tgt_eff   <= target_effect;
                r_tgt_mode  <= target_mode;
            end
            case (r_state)
                c_st_fade_out: begin
                    if (sample_valid) begin
                        r_fb  <= f_step_amount(r_fb, 8'd0);
                        r_eff <= f_step_amount(r_eff, 8'd0);
                    end
                end
                c_st_switch: begin
                    // Wet path is silent here, so the delay may jump.
                    r_mode      <= r_tgt_mode;
                    r_delay     <= r_tgt_delay;
                    r_flush_cnt <= '0;
                end
                c_st_flush: begin
                    if (sample_valid && (r_flush_cnt != r_tgt_delay)) begin
                        r_flush_cnt <= r_flush_cnt + c_cnt_one;
                    end
                end
                c_st_glide: begin
                    if (sample_valid) begin
                        r_delay <= f_step_delay(r_delay, r_tgt_delay);
                        r_fb    <= f_step_amount(r_fb, r_tgt_fb);
                        r_eff   <= f_step_amount(r_eff, r_tgt_eff);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cfg_ready       = w_cfg_ready;
    assign busy            = w_busy;
    assign delay_samples   = r_delay;
    assign feedback_amount = r_fb;
    assign effect_amount   = r_eff;
    assign mode            = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_delay_param_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_delay_param_sequencer
// Description : Directed self-checking bench for delay_param_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_param_sequencer;

    logic        clk;
    logic        reset;
    logic        sample_valid;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] target_delay;
    logic [7:0]  target_feedback;
    logic [7:0]  target_effect;
    logic        target_mode;
    logic [15:0] delay_samples;
    logic [7:0]  feedback_amount;
    logic [7:0]  effect_amount;
    logic        mode;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    delay_param_sequencer #(
        .ADDR_WIDTH (16),
        .DELAY_STEP (4),
        .FADE_STEP  (2),
        .RESET_DELAY(4800)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .target_delay   (target_delay),
        .target_feedback(target_feedback),
        .target_effect  (target_effect),
        .target_mode    (target_mode),
        .delay_samples  (delay_samples),
        .feedback_amount(feedback_amount),
        .effect_amount  (effect_amount),
        .mode           (mode),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic tick();
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cfg(input logic [15:0] d, input logic [7:0] fb,
                            input logic [7:0] eff, input logic m);
        cfg_valid       = 1'b1;
        target_delay    = d;
        target_feedback = fb;
        target_effect   = eff;
        target_mode     = m;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int d, input int fb,
                              input int eff, input int m);
        check({tag, "_delay"}, 32'(delay_samples), d);
        check({tag, "_fb"}, 32'(feedback_amount), fb);
        check({tag, "_eff"}, 32'(effect_amount), eff);
        check({tag, "_mode"}, 32'(mode), m);
    endtask

    initial begin
        reset           = 1'b1;
        sample_valid    = 1'b0;
        cfg_valid       = 1'b0;
        target_delay    = '0;
        target_feedback = '0;
        target_effect   = '0;
        target_mode     = 1'b0;
        idle_clk(3);
        reset = 1'b0;
        idle_clk(1);

        // Reset state and a no-op config.
        check_outs("rst", 4800, 0, 0, 0);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_busy", 32'(busy), 0);
        send_cfg(16'd4800, 8'd0, 8'd0, 1'b0);
        check("noop_busy", 32'(busy), 1);
        check("noop_ready", 32'(cfg_ready), 0);
        idle_clk(1);
        check("noop_busy_end", 32'(busy), 0);
        check("noop_ready_end", 32'(cfg_ready), 1);
        check_outs("noop", 4800, 0, 0, 0);

        // Delay glide up with a tick every 8 clocks.
        send_cfg(16'd4810, 8'd0, 8'd0, 1'b0);
        tick();
        check("glide_d1", 32'(delay_samples), 4804);
        idle_clk(7);
        check("glide_d1_hold", 32'(delay_samples), 4804);
        tick();
        check("glide_d2", 32'(delay_samples), 4808);
        idle_clk(7);
        tick();
        check("glide_d3", 32'(delay_samples), 4810);
        idle_clk(1);
        check("glide_idle", 32'(busy), 0);

        // Mix fade up then down.
        send_cfg(16'd4810, 8'd4, 8'd5, 1'b0);
        tick(); check("up_eff1", 32'(effect_amount), 2); check("up_fb1", 32'(feedback_amount), 2);
        tick(); check("up_eff2", 32'(effect_amount), 4); check("up_fb2", 32'(feedback_amount), 4);
        tick(); check("up_eff3", 32'(effect_amount), 5); check("up_fb3", 32'(feedback_amount), 4);
        idle_clk(1);
        check("up_idle", 32'(busy), 0);
        send_cfg(16'd4810, 8'd0, 8'd0, 1'b0);
        tick(); check("dn_eff1", 32'(effect_amount), 3); check("dn_fb1", 32'(feedback_amount), 2);
        tick(); check("dn_eff2", 32'(effect_amount), 1); check("dn_fb2", 32'(feedback_amount), 0);
        tick(); check("dn_eff3", 32'(effect_amount), 0); check("dn_fb3", 32'(feedback_amount), 0);
        idle_clk(1);
        check("dn_idle", 32'(busy), 0);

        // Set up eff=4, fb=2, delay=4800 for the mode change.
        send_cfg(16'd4800, 8'd2, 8'd4, 1'b0);
        tick(); check_outs("pre1", 4806, 2, 2, 0);
        tick(); check_outs("pre2", 4802, 2, 4, 0);
        tick(); check_outs("pre3", 4800, 2, 4, 0);
        idle_clk(1);
        check("pre_idle", 32'(busy), 0);

        // Mode change: fade out, switch, flush 10 ticks, fade in.
        send_cfg(16'd10, 8'd2, 8'd4, 1'b1);
        tick(); check_outs("fo1", 4800, 0, 2, 0);
        tick(); check_outs("fo2", 4800, 0, 0, 0);
        idle_clk(1);
        tick();  // lands on the SWITCH cycle and must not count toward the flush
        check_outs("sw", 10, 0, 0, 1);
        check("sw_busy", 32'(busy), 1);
        repeat (9) tick();
        idle_clk(1);
        tick();
        check_outs("flush10", 10, 0, 0, 1);
        idle_clk(1);
        tick(); check_outs("fi1", 10, 2, 2, 1);
        tick(); check_outs("fi2", 10, 2, 4, 1);
        idle_clk(1);
        check("mc_idle", 32'(busy), 0);

        // Config offered while busy is dropped.
        send_cfg(16'd30, 8'd2, 8'd4, 1'b1);
        tick();
        check("drop_d1", 32'(delay_samples), 14);
        send_cfg(16'd100, 8'd0, 8'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
        end
        check("drop_timeout_busy", 32'(busy), 0);
        check_outs("drop", 30, 2, 4, 1);

        // Reset in the middle of a flush.
        send_cfg(16'd20, 8'd0, 8'd0, 1'b0);
        tick(); check_outs("rfo1", 30, 0, 2, 1);
        tick();
        idle_clk(2);
        check_outs("rsw", 20, 0, 0, 0);
        repeat (3) tick();
        check("rflush_busy", 32'(busy), 1);
        reset = 1'b1;
        idle_clk(1);
        reset = 1'b0;
        check_outs("mid_rst", 4800, 0, 0, 0);
        check("mid_rst_ready", 32'(cfg_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        send_cfg(16'd4804, 8'd2, 8'd2, 1'b0);
        check("post_busy", 32'(busy), 1);
        tick(); check_outs("post", 4804, 2, 2, 0);
        idle_clk(1);
        check("post_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
